// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: the per-stage
// destination/source slot record and the "does this slot write r" predicate.
package pipe_pkg;

   localparam int MAX_REG_W     = 8;
   localparam int FWD_REG       = 0;
   localparam int MAX_FWD_DEPTH = 3;

   typedef logic [MAX_REG_W-1:0] reg_idx_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rd;
      logic     regwrite;
      logic     memread;
      logic     multicycle;
      reg_idx_t rs1;
      reg_idx_t rs2;
      logic     rs1_used;
      logic     rs2_used;
   } slot_t;

   // x0 is hardwired, so a write to it never produces a forwardable value.
   function automatic logic slot_writes(slot_t s, reg_idx_t r);
      return s.valid && s.regwrite && (s.rd == r) && (r != '0);
   endfunction

endpackage

// File: rtl/hazard_fwd_select.sv
// Priority scan over the post-EX slots for one EX source register; the
// youngest (smallest index) producer wins.
module hazard_fwd_select
   import pipe_pkg::*;
#(
   parameter int FWD_DEPTH = 2,
   parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  slot_t            slots [0:FWD_DEPTH],
   input  reg_idx_t         src,
   input  logic             src_used,
   output logic [SEL_W-1:0] sel
);

   logic unused_meta;

   always_comb begin
      // NOTE: every always_comb output gets a default first, otherwise the paths that skip the assignment infer a latch.
      sel = SEL_W'(FWD_REG);
      if (slots[0].valid && src_used) begin
         for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (slot_writes(slots[k], src)) sel = SEL_W'(k);
         end
      end
   end

   always_comb begin
      unused_meta = 1'b0;
      for (int k = 0; k <= FWD_DEPTH; k++) unused_meta = unused_meta ^ (^slots[k]);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/forwarding controller: shadow pipeline of EX..bypass metadata,
// EX operand forwarding selects, load-use stall, multi-cycle hold, branch squash.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int FWD_DEPTH  = 2,
   parameter int LOAD_LAT   = 1,
   parameter int MC_LAT     = 4,
   parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  id_multicycle,
   input  logic                  ex_branch_taken,
   output logic [SEL_W-1:0]      ex_fwd_a,
   output logic [SEL_W-1:0]      ex_fwd_b,
   output logic                  pc_stall,
   output logic                  ifid_stall,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic                  ex_busy
);

   localparam int MC_W = $clog2(MC_LAT);

   slot_t            slot_q [0:FWD_DEPTH];
   slot_t            id_slot;
   logic [MC_W-1:0]  mc_cnt;
   logic             busy;
   logic             lu_stall;
   logic [SEL_W-1:0] sel_a;
   logic [SEL_W-1:0] sel_b;
   logic             unused_meta;

   always_comb begin
      id_slot            = '0;
      id_slot.valid      = id_valid;
      id_slot.rd         = reg_idx_t'(id_rd);
      id_slot.regwrite   = id_regwrite;
      id_slot.memread    = id_memread;
      id_slot.multicycle = id_multicycle;
      id_slot.rs1        = reg_idx_t'(id_rs1);
      id_slot.rs2        = reg_idx_t'(id_rs2);
      id_slot.rs1_used   = id_rs1_used;
      id_slot.rs2_used   = id_rs2_used;
   end

   assign busy = (mc_cnt != '0);

   // A load still within LOAD_LAT stages of ID cannot supply its data in time.
   always_comb begin
      lu_stall = 1'b0;
      for (int j = 0; j < LOAD_LAT; j++) begin
         if (slot_q[j].memread &&
             ((id_rs1_used && slot_writes(slot_q[j], id_slot.rs1)) ||
              (id_rs2_used && slot_writes(slot_q[j], id_slot.rs2))))
            lu_stall = 1'b1;
      end
      lu_stall = lu_stall & id_valid;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the slot array is control state (valid bits drive stalls), so unlike a data RAM it must be reset.
         for (int k = 0; k <= FWD_DEPTH; k++) slot_q[k] <= '0;
         mc_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments let every slot read its neighbour's pre-edge value, giving a true shift.
         for (int k = FWD_DEPTH; k >= 2; k--) slot_q[k] <= slot_q[k-1];
         if (busy) begin
            slot_q[1] <= '0;
            mc_cnt    <= mc_cnt - MC_W'(1);
         end else begin
            slot_q[1] <= slot_q[0];
            if (ex_branch_taken || lu_stall) begin
               slot_q[0] <= '0;
            end else begin
               slot_q[0] <= id_slot;
               if (id_valid && id_multicycle) mc_cnt <= MC_W'(MC_LAT - 1);
            end
         end
      end
   end

   hazard_fwd_select #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_fwd_a (
      .slots    (slot_q),
      .src      (slot_q[0].rs1),
      .src_used (slot_q[0].rs1_used),
      .sel      (sel_a)
   );

   hazard_fwd_select #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_fwd_b (
      .slots    (slot_q),
      .src      (slot_q[0].rs2),
      .src_used (slot_q[0].rs2_used),
      .sel      (sel_b)
   );

   // Outputs are forced low for as long as reset is held, including input-driven terms.
   always_comb begin
      ex_fwd_a    = '0;
      ex_fwd_b    = '0;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      ex_busy     = 1'b0;
      if (reset) begin
         ex_fwd_a = sel_a;
         ex_fwd_b = sel_b;
         ex_busy  = busy;
         if (busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
         end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (lu_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
         end
      end
   end

   always_comb begin
      unused_meta = 1'b0;
      for (int k = 0; k <= FWD_DEPTH; k++) unused_meta = unused_meta ^ (^slot_q[k]);
   end

endmodule
